vec_mem_responder: RTL

- Memory-side responder for the vector pipeline's MEM stage. It accepts single-word write/read requests and auto-incrementing burst reads over a valid/ready request channel.
- It returns read data over a valid/ready response channel with per-beat backpressure.
- It replaces the stand-alone test RAM hookup. The MEM stage (initiator) drives requests; this block serves them from internal synchronous storage.

---
 rtl/vec_mem_pkg.sv | 14 +
 rtl/vec_mem_array.sv | 38 +++
 rtl/vec_mem_responder.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/vec_mem_pkg.sv
// Shared types and sizing constants for the vector MEM-stage responder.
package vec_mem_pkg;

  localparam int unsigned VMEM_ADDR_W = 8;
  localparam int unsigned VMEM_DATA_W = 32;
  localparam int unsigned VMEM_DEPTH  = 256;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    RESP  = 2'd2
  } state_e;

endpackage

// File: rtl/vec_mem_array.sv
// Single-port synchronous RAM; read data is registered and only updates on rden_i.
module vec_mem_array
  import vec_mem_pkg::*;
#(
  parameter int unsigned ADDR_W = VMEM_ADDR_W,
  parameter int unsigned DATA_W = VMEM_DATA_W,
  parameter int unsigned DEPTH  = VMEM_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wren_i,
  input  logic              rden_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Storage is deliberately not cleared by reset.
  always_ff @(posedge clk) begin
    if (wren_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q <= '0;
    end else if (rden_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/vec_mem_responder.sv
// MEM-stage memory responder: single writes, single reads and wrapping burst reads
// served from internal storage with per-beat valid/ready backpressure.
module vec_mem_responder
  import vec_mem_pkg::*;
#(
  parameter int unsigned ADDR_W = VMEM_ADDR_W,
  parameter int unsigned DATA_W = VMEM_DATA_W,
  parameter int unsigned DEPTH  = VMEM_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic              req_burst,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_final,
  input  logic [DATA_W-1:0] req_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic              rsp_last,
  output logic              busy
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W-1:0] fin_q, fin_d;
  logic [ADDR_W-1:0] rsp_addr_q, rsp_addr_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_last_q, rsp_last_d;
  logic              req_ready_q, req_ready_d;
  logic              busy_q, busy_d;

  logic              req_accept_c;
  logic [ADDR_W-1:0] req_idx_c;
  logic [ADDR_W-1:0] fin_idx_c;
  logic              ram_wren_c;
  logic              ram_rden_c;
  logic [ADDR_W-1:0] ram_addr_c;
  logic              unused_upper_c;

  assign req_accept_c   = req_valid && req_ready_q;
  assign req_idx_c      = req_addr[ADDR_W-1:0];
  assign fin_idx_c      = req_final[ADDR_W-1:0];
  assign unused_upper_c = ^{req_addr[31:ADDR_W], req_final[31:ADDR_W]};

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_accept_c && !req_wr) state_d = FETCH;
      FETCH:   state_d = RESP;
      RESP:    if (rsp_ready) state_d = rsp_last_q ? IDLE : FETCH;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values and RAM control
  always_comb begin
    ptr_d       = ptr_q;
    fin_d       = fin_q;
    rsp_valid_d = rsp_valid_q;
    rsp_addr_d  = rsp_addr_q;
    rsp_last_d  = rsp_last_q;
    ram_wren_c  = 1'b0;
    ram_rden_c  = 1'b0;
    ram_addr_c  = ptr_q;
    case (state_q)
      IDLE: begin
        if (req_accept_c) begin
          if (req_wr) begin
            ram_wren_c = !reset;
            ram_addr_c = req_idx_c;
          end else begin
            ptr_d = req_idx_c;
            fin_d = req_burst ? fin_idx_c : req_idx_c;
          end
        end
      end
      FETCH: begin
        ram_rden_c  = 1'b1;
        rsp_valid_d = 1'b1;
        rsp_addr_d  = ptr_q;
        rsp_last_d  = (ptr_q == fin_q);
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          // Pointer wraps naturally at DEPTH since DEPTH == 2**ADDR_W.
          if (!rsp_last_q) ptr_d = ptr_q + ADDR_W'(1);
        end
      end
      default: ;
    endcase
    req_ready_d = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q       <= '0;
      fin_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_addr_q  <= '0;
      rsp_last_q  <= 1'b0;
      req_ready_q <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      fin_q       <= fin_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_addr_q  <= rsp_addr_d;
      rsp_last_q  <= rsp_last_d;
      req_ready_q <= req_ready_d;
      busy_q      <= busy_d;
    end
  end

  vec_mem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk     (clk),
    .reset   (reset),
    .wren_i  (ram_wren_c),
    .rden_i  (ram_rden_c),
    .addr_i  (ram_addr_c),
    .wdata_i (req_data),
    .rdata_o (rsp_data)
  );

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_addr  = rsp_addr_q;
  assign rsp_last  = rsp_last_q;
  assign busy      = busy_q;

endmodule
